// File: rtl/dma_priority_arbiter.sv
// dma_priority_arbiter: 4-channel DMA request arbiter with fixed/rotating priority and CPU hold handshake.
// Define DMA_SW_REQUEST_EN to add the swRequest input (software requests bypass mask and sense).
module dma_priority_arbiter (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] DREQ,
  input  logic [3:0] maskReg,
  input  logic       dreqSenseLow,
  input  logic       rotatingPriority,
  input  logic       controllerDisable,
  input  logic       HLDA,
  input  logic       serviceDone,
`ifdef DMA_SW_REQUEST_EN
  input  logic [3:0] swRequest,
`endif
  output logic       HRQ,
  output logic [3:0] DACK,
  output logic       grantValid,
  output logic [1:0] grantChannel,
  output logic [7:0] priorityOrder
);

  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = 2;
  localparam logic [7:0] FIXED_ORDER = 8'b11_10_01_00;

  typedef enum logic [1:0] {S_IDLE, S_HREQ, S_SERVE} state_t;

  state_t           r_state;
  logic             r_hrq;
  logic [NCH-1:0]   r_dack;
  logic             r_grant_valid;
  logic [CW-1:0]    r_grant_ch;
  logic [7:0]       r_order;

  logic [NCH-1:0]   w_req;
  logic             w_any;
  logic [CW-1:0]    w_winner;
  logic             w_found;
  logic [7:0]       w_rot_order;

`ifdef DMA_SW_REQUEST_EN
  assign w_req = ((DREQ ^ {NCH{dreqSenseLow}}) & ~maskReg) | swRequest;
`else
  assign w_req = (DREQ ^ {NCH{dreqSenseLow}}) & ~maskReg;
`endif

  assign w_any = |w_req;

  // Finished channel drops to lowest priority; its successor becomes highest.
  assign w_rot_order = {r_grant_ch, r_grant_ch + 2'd3, r_grant_ch + 2'd2, r_grant_ch + 2'd1};

  // Scan priority fields from highest ([1:0]) to lowest, first active request wins.
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (!w_found && w_req[r_order[k*CW +: CW]]) begin
        w_winner = r_order[k*CW +: CW];
        w_found  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state       <= S_IDLE;
      r_hrq         <= 1'b0;
      r_dack        <= '0;
      r_grant_valid <= 1'b0;
      r_grant_ch    <= '0;
      r_order       <= FIXED_ORDER;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!controllerDisable && w_any) begin
            r_state <= S_HREQ;
            r_hrq   <= 1'b1;
          end
        end
        S_HREQ: begin
          if (HLDA) begin
            if (w_found) begin
              r_state       <= S_SERVE;
              r_dack        <= NCH'(1) << w_winner;
              r_grant_valid <= 1'b1;
              r_grant_ch    <= w_winner;
            end else begin
              r_state <= S_IDLE;
              r_hrq   <= 1'b0;
            end
          end
        end
        S_SERVE: begin
          // Completion takes precedence over a simultaneous hold drop.
          if (serviceDone || !HLDA) begin
            r_state       <= S_IDLE;
            r_hrq         <= 1'b0;
            r_dack        <= '0;
            r_grant_valid <= 1'b0;
            r_grant_ch    <= '0;
            if (serviceDone && rotatingPriority) begin
              r_order <= w_rot_order;
            end
          end
        end
        default: begin
          r_state       <= S_IDLE;
          r_hrq         <= 1'b0;
          r_dack        <= '0;
          r_grant_valid <= 1'b0;
          r_grant_ch    <= '0;
        end
      endcase
      if (!rotatingPriority) begin
        r_order <= FIXED_ORDER;
      end
    end
  end

  assign HRQ           = r_hrq;
  assign DACK          = r_dack;
  assign grantValid    = r_grant_valid;
  assign grantChannel  = r_grant_ch;
  assign priorityOrder = r_order;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Self-checking bench for dma_priority_arbiter: directed scenarios plus randomized transactions
// checked against an array-based priority model.
module tb_dma_priority_arbiter;

  logic       CLK;
  logic       RESET;
  logic [3:0] DREQ;
  logic [3:0] maskReg;
  logic       dreqSenseLow;
  logic       rotatingPriority;
  logic       controllerDisable;
  logic       HLDA;
  logic       serviceDone;
`ifdef DMA_SW_REQUEST_EN
  logic [3:0] swRequest;
`endif
  logic       HRQ;
  logic [3:0] DACK;
  logic       grantValid;
  logic [1:0] grantChannel;
  logic [7:0] priorityOrder;

  int n_chk  = 0;
  int n_fail = 0;

  int         m_ord [4];
  logic [3:0] dreq, mask, exp_req;
  bit         rot, sense, abort;
  int         win;

  dma_priority_arbiter dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .DREQ             (DREQ),
    .maskReg          (maskReg),
    .dreqSenseLow     (dreqSenseLow),
    .rotatingPriority (rotatingPriority),
    .controllerDisable(controllerDisable),
    .HLDA             (HLDA),
    .serviceDone      (serviceDone),
`ifdef DMA_SW_REQUEST_EN
    .swRequest        (swRequest),
`endif
    .HRQ              (HRQ),
    .DACK             (DACK),
    .grantValid       (grantValid),
    .grantChannel     (grantChannel),
    .priorityOrder    (priorityOrder)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [7:0] pack_ord();
    return {2'(m_ord[3]), 2'(m_ord[2]), 2'(m_ord[1]), 2'(m_ord[0])};
  endfunction

  task automatic test_reset();
    RESET = 1'b1;
    #3;
    n_chk++;
    if ({HRQ, DACK, grantValid, grantChannel, priorityOrder} !== {1'b0, 4'b0, 1'b0, 2'b0, 8'hE4}) begin
      n_fail++;
      $display("FAIL reset_state: got %b want %b", {HRQ, DACK, grantValid, grantChannel, priorityOrder},
               {1'b0, 4'b0, 1'b0, 2'b0, 8'hE4});
    end
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_fixed();
    rotatingPriority = 1'b0;
    DREQ = 4'b1010;
    @(negedge CLK);
    n_chk++;
    if ({HRQ, DACK} !== 5'b1_0000) begin
      n_fail++; $display("FAIL fixed_hrq_latency: got %b want %b", {HRQ, DACK}, 5'b1_0000);
    end
    @(negedge CLK);
    HLDA = 1'b1;
    @(negedge CLK);
    n_chk++;
    if ({DACK, grantValid, grantChannel} !== {4'b0010, 1'b1, 2'd1}) begin
      n_fail++; $display("FAIL fixed_grant: got %b want %b", {DACK, grantValid, grantChannel}, 7'b0010_1_01);
    end
    DREQ = 4'b1111;
    @(negedge CLK);
    n_chk++;
    if (DACK !== 4'b0010) begin
      n_fail++; $display("FAIL fixed_hold: got %b want %b", DACK, 4'b0010);
    end
    serviceDone = 1'b1;
    @(negedge CLK);
    serviceDone = 1'b0; HLDA = 1'b0; DREQ = 4'b0000;
    n_chk++;
    if ({HRQ, DACK, grantValid, priorityOrder} !== {1'b0, 4'b0, 1'b0, 8'hE4}) begin
      n_fail++; $display("FAIL fixed_done: got %b want %b", {HRQ, DACK, grantValid, priorityOrder}, 14'h00E4);
    end
    @(negedge CLK);
  endtask

  task automatic test_rotate();
    rotatingPriority = 1'b1;
    DREQ = 4'b0100;
    @(negedge CLK);
    HLDA = 1'b1;
    @(negedge CLK);
    n_chk++;
    if (DACK !== 4'b0100) begin
      n_fail++; $display("FAIL rot_grant2: got %b want %b", DACK, 4'b0100);
    end
    serviceDone = 1'b1;
    @(negedge CLK);
    serviceDone = 1'b0; HLDA = 1'b0; DREQ = 4'b0101;
    n_chk++;
    if (priorityOrder !== 8'b10_01_00_11) begin
      n_fail++; $display("FAIL rot_order2: got %b want %b", priorityOrder, 8'b10_01_00_11);
    end
    @(negedge CLK);
    HLDA = 1'b1;
    @(negedge CLK);
    n_chk++;
    if ({DACK, grantChannel} !== {4'b0001, 2'd0}) begin
      n_fail++; $display("FAIL rot_grant0: got %b want %b", {DACK, grantChannel}, 6'b0001_00);
    end
    serviceDone = 1'b1;
    @(negedge CLK);
    serviceDone = 1'b0; HLDA = 1'b0; DREQ = 4'b0000;
    n_chk++;
    if (priorityOrder !== 8'b00_11_10_01) begin
      n_fail++; $display("FAIL rot_order0: got %b want %b", priorityOrder, 8'b00_11_10_01);
    end
    @(negedge CLK);
  endtask

  task automatic test_mask_sense();
    rotatingPriority = 1'b0;
    maskReg = 4'b0001; DREQ = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      n_chk++;
      if (HRQ !== 1'b0) begin
        n_fail++; $display("FAIL masked_hrq: got %b want %b", HRQ, 1'b0);
      end
    end
    maskReg = 4'b0000; dreqSenseLow = 1'b1; DREQ = 4'b1110;
    @(negedge CLK);
    HLDA = 1'b1;
    @(negedge CLK);
    n_chk++;
    if ({DACK, grantChannel} !== {4'b0001, 2'd0}) begin
      n_fail++; $display("FAIL sense_low_grant: got %b want %b", {DACK, grantChannel}, 6'b0001_00);
    end
    serviceDone = 1'b1;
    @(negedge CLK);
    serviceDone = 1'b0; HLDA = 1'b0; dreqSenseLow = 1'b0; DREQ = 4'b0000;
    @(negedge CLK);
  endtask

  task automatic test_no_preempt_abort();
    rotatingPriority = 1'b1;
    DREQ = 4'b0010;
    @(negedge CLK);
    HLDA = 1'b1;
    @(negedge CLK);
    serviceDone = 1'b1;
    @(negedge CLK);
    serviceDone = 1'b0; HLDA = 1'b0; DREQ = 4'b1000;
    n_chk++;
    if (priorityOrder !== 8'b01_00_11_10) begin
      n_fail++; $display("FAIL abort_pre_order: got %b want %b", priorityOrder, 8'b01_00_11_10);
    end
    @(negedge CLK);
    HLDA = 1'b1;
    @(negedge CLK);
    n_chk++;
    if (DACK !== 4'b1000) begin
      n_fail++; $display("FAIL ch3_grant: got %b want %b", DACK, 4'b1000);
    end
    DREQ = 4'b1001;
    @(negedge CLK);
    n_chk++;
    if (DACK !== 4'b1000) begin
      n_fail++; $display("FAIL no_preempt: got %b want %b", DACK, 4'b1000);
    end
    HLDA = 1'b0; DREQ = 4'b0000;
    @(negedge CLK);
    n_chk++;
    if ({HRQ, DACK, grantValid, priorityOrder} !== {1'b0, 4'b0, 1'b0, 8'b01_00_11_10}) begin
      n_fail++; $display("FAIL abort_clear: got %b want %b", {HRQ, DACK, grantValid, priorityOrder},
                         {6'b0, 8'b01_00_11_10});
    end
    @(negedge CLK);
  endtask

  task automatic test_hreq_drop();
    rotatingPriority = 1'b0;
    DREQ = 4'b0010;
    @(negedge CLK);
    DREQ = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      n_chk++;
      if (HRQ !== 1'b1) begin
        n_fail++; $display("FAIL hrq_held: got %b want %b", HRQ, 1'b1);
      end
    end
    HLDA = 1'b1;
    @(negedge CLK);
    n_chk++;
    if ({HRQ, DACK, grantValid} !== 6'b0) begin
      n_fail++; $display("FAIL hreq_release: got %b want %b", {HRQ, DACK, grantValid}, 6'b0);
    end
    HLDA = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_disable();
    controllerDisable = 1'b1; DREQ = 4'b0001;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      n_chk++;
      if (HRQ !== 1'b0) begin
        n_fail++; $display("FAIL disable_idle: got %b want %b", HRQ, 1'b0);
      end
    end
    controllerDisable = 1'b0;
    @(negedge CLK);
    HLDA = 1'b1;
    @(negedge CLK);
    controllerDisable = 1'b1;
    @(negedge CLK);
    n_chk++;
    if ({DACK, grantValid} !== 5'b0001_1) begin
      n_fail++; $display("FAIL disable_serve: got %b want %b", {DACK, grantValid}, 5'b0001_1);
    end
    serviceDone = 1'b1;
    @(negedge CLK);
    serviceDone = 1'b0; HLDA = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      n_chk++;
      if ({HRQ, DACK} !== 5'b0) begin
        n_fail++; $display("FAIL disable_no_rearb: got %b want %b", {HRQ, DACK}, 5'b0);
      end
    end
    controllerDisable = 1'b0; DREQ = 4'b0000;
    @(negedge CLK);
  endtask

  task automatic test_done_in_idle();
    rotatingPriority = 1'b1;
    serviceDone = 1'b1;
    @(negedge CLK);
    serviceDone = 1'b0;
    @(negedge CLK);
    n_chk++;
    if ({HRQ, priorityOrder} !== {1'b0, 8'hE4}) begin
      n_fail++; $display("FAIL done_idle_ignored: got %b want %b", {HRQ, priorityOrder}, 9'h0E4);
    end
  endtask

  task automatic test_reset_mid_serve();
    rotatingPriority = 1'b1;
    DREQ = 4'b0100;
    @(negedge CLK);
    HLDA = 1'b1;
    @(negedge CLK);
    serviceDone = 1'b1;
    @(negedge CLK);
    serviceDone = 1'b0; HLDA = 1'b0;
    @(negedge CLK);
    HLDA = 1'b1;
    @(negedge CLK);
    n_chk++;
    if ({DACK, priorityOrder} !== {4'b0100, 8'b10_01_00_11}) begin
      n_fail++; $display("FAIL pre_reset_serve: got %b want %b", {DACK, priorityOrder}, {4'b0100, 8'b10_01_00_11});
    end
    #2 RESET = 1'b1;
    #1;
    n_chk++;
    if ({HRQ, DACK, grantValid, priorityOrder} !== {1'b0, 4'b0, 1'b0, 8'hE4}) begin
      n_fail++; $display("FAIL async_reset: got %b want %b", {HRQ, DACK, grantValid, priorityOrder}, 14'h00E4);
    end
    @(negedge CLK);
    RESET = 1'b0; HLDA = 1'b0;
    @(negedge CLK);
    n_chk++;
    if ({HRQ, DACK} !== 5'b1_0000) begin
      n_fail++; $display("FAIL post_reset_hrq: got %b want %b", {HRQ, DACK}, 5'b1_0000);
    end
    DREQ = 4'b0000; HLDA = 1'b1;
    @(negedge CLK);
    HLDA = 1'b0;
    @(negedge CLK);
  endtask

`ifdef DMA_SW_REQUEST_EN
  task automatic test_sw_request();
    rotatingPriority = 1'b0;
    maskReg = 4'b1111; swRequest = 4'b0100;
    @(negedge CLK);
    HLDA = 1'b1;
    @(negedge CLK);
    n_chk++;
    if (DACK !== 4'b0100) begin
      n_fail++; $display("FAIL sw_request: got %b want %b", DACK, 4'b0100);
    end
    serviceDone = 1'b1;
    @(negedge CLK);
    serviceDone = 1'b0; HLDA = 1'b0; swRequest = 4'b0000; maskReg = 4'b0000;
    @(negedge CLK);
  endtask
`endif

  task automatic test_random();
    rotatingPriority = 1'b0;
    m_ord = '{0, 1, 2, 3};
    @(negedge CLK);
    for (int t = 0; t < 60; t++) begin
      rot = 1'($urandom_range(0, 1)); sense = 1'($urandom_range(0, 1));
      mask = 4'($urandom); dreq = 4'($urandom);
      if (!rot) m_ord = '{0, 1, 2, 3};
      exp_req = (dreq ^ {4{sense}}) & ~mask;
      win = -1;
      for (int k = 3; k >= 0; k--) if (exp_req[m_ord[k]]) win = m_ord[k];
      rotatingPriority = rot; dreqSenseLow = sense; maskReg = mask; DREQ = dreq;
      @(negedge CLK);
      n_chk++;
      if (HRQ !== (exp_req != 4'b0)) begin
        n_fail++; $display("FAIL rnd_hrq[%0d]: got %b want %b", t, HRQ, (exp_req != 4'b0));
      end
      n_chk++;
      if (priorityOrder !== pack_ord()) begin
        n_fail++; $display("FAIL rnd_order_pre[%0d]: got %b want %b", t, priorityOrder, pack_ord());
      end
      if (win >= 0) begin
        HLDA = 1'b1;
        @(negedge CLK);
        n_chk++;
        if ({DACK, grantValid, grantChannel} !== {4'(1) << win, 1'b1, 2'(win)}) begin
          n_fail++; $display("FAIL rnd_grant[%0d]: got %b want %b", t, {DACK, grantValid, grantChannel},
                             {4'(1) << win, 1'b1, 2'(win)});
        end
        DREQ = 4'($urandom);
        abort = ($urandom_range(0, 3) == 0);
        if (abort) HLDA = 1'b0;
        else serviceDone = 1'b1;
        @(negedge CLK);
        if (!abort && rot) m_ord = '{(win + 1) % 4, (win + 2) % 4, (win + 3) % 4, win};
        n_chk++;
        if ({HRQ, DACK, grantValid} !== 6'b0) begin
          n_fail++; $display("FAIL rnd_release[%0d]: got %b want %b", t, {HRQ, DACK, grantValid}, 6'b0);
        end
        n_chk++;
        if (priorityOrder !== pack_ord()) begin
          n_fail++; $display("FAIL rnd_order_post[%0d]: got %b want %b", t, priorityOrder, pack_ord());
        end
      end
      DREQ = {4{sense}}; HLDA = 1'b0; serviceDone = 1'b0;
      @(negedge CLK);
    end
  endtask

  initial begin
    RESET = 1'b1; DREQ = 4'b0; maskReg = 4'b0; dreqSenseLow = 1'b0;
    rotatingPriority = 1'b0; controllerDisable = 1'b0; HLDA = 1'b0; serviceDone = 1'b0;
`ifdef DMA_SW_REQUEST_EN
    swRequest = 4'b0;
`endif
    test_reset();
    test_fixed();
    test_rotate();
    test_mask_sense();
    test_no_preempt_abort();
    test_hreq_drop();
    test_disable();
    test_done_in_idle();
    test_reset_mid_serve();
`ifdef DMA_SW_REQUEST_EN
    test_sw_request();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  always @(negedge CLK) begin
    if (!RESET && !$isunknown(DACK) && !$onehot0(DACK)) begin
      n_fail++;
      $display("FAIL dack_onehot: got %b want one-hot or zero", DACK);
    end
  end

endmodule

// File: doc/dma_priority_arbiter.md
DMA_PRIORITY_ARBITER -- requirements
Module: dma_priority_arbiter

Interface
REQ-001 CLK  input  1  single clock; all state updates on rising edge.
REQ-002 RESET  input  1  asynchronous, active-high reset; clears all state immediately, independent of CLK.
REQ-003 DREQ  input  4  channel DMA requests, polarity set by dreqSenseLow.
REQ-004 maskReg  input  4  per-channel mask; 1 = hardware request ignored.
REQ-005 dreqSenseLow  input  1  0 = DREQ active-high, 1 = DREQ active-low.
REQ-006 rotatingPriority  input  1  0 = fixed priority, 1 = rotating priority.
REQ-007 controllerDisable  input  1  1 = no new arbitration starts.
REQ-008 HLDA  input  1  hold acknowledge from CPU.
REQ-009 serviceDone  input  1  one-cycle pulse from timing control at end of granted service (TC/EOP/demand drop).
REQ-010 HRQ  output  1  hold request to CPU.
REQ-011 DACK  output  4  one-hot active-high acknowledge to granted channel.
REQ-012 grantValid  output  1  high while a channel is being serviced.
REQ-013 grantChannel  output  2  index of serviced channel, valid when grantValid=1.
REQ-014 priorityOrder  output  8  four 2-bit channel fields, [1:0] = highest priority, [7:6] = lowest.

Function
REQ-015 Effective request req[i] SHALL be (DREQ[i] XOR dreqSenseLow) AND NOT maskReg[i] (plus software request, REQ-032).
REQ-016 FSM states SHALL be IDLE, HREQ, SERVE; all outputs registered.
REQ-017 IDLE: if controllerDisable=0 and any req[i]=1 -> HREQ; HRQ=1 from the next cycle (1-cycle DREQ-to-HRQ latency).
REQ-018 HREQ: HRQ held 1; when HLDA=1 and any req active, the highest-priority active channel per priorityOrder SHALL be latched as winner -> SERVE.
REQ-019 HREQ: if HLDA=1 and no req active -> IDLE, HRQ=0 next cycle; if req drops while HLDA=0, HRQ SHALL remain 1 until HLDA or a request-free HLDA cycle.
REQ-020 SERVE: DACK[winner]=1, grantValid=1, grantChannel=winner, HRQ=1; first DACK cycle is one cycle after HLDA sampled high.
REQ-021 A higher-priority request arriving in SERVE SHALL NOT preempt; winner held until serviceDone.
REQ-022 serviceDone=1 in SERVE -> IDLE; DACK, grantValid, HRQ all 0 the next cycle; re-arbitration earliest one cycle later.
REQ-023 HLDA falling to 0 in SERVE SHALL abort -> IDLE, outputs cleared next cycle, no priority rotation.
REQ-024 controllerDisable=1 during HREQ or SERVE SHALL NOT abort; current cycle completes, no new HREQ from IDLE.
REQ-025 Fixed mode: priorityOrder SHALL be forced to 8'b11_10_01_00 (channel 0 highest) on every cycle rotatingPriority=0.
REQ-026 Rotating mode: on serviceDone for channel n, priorityOrder SHALL become {n, n+3, n+2, n+1} (mod 4, MSB field first), i.e. n lowest, n+1 highest.
REQ-027 serviceDone outside SERVE SHALL be ignored.
REQ-028 DACK SHALL be one-hot or zero at all times.

Reset
REQ-029 RESET=1 SHALL asynchronously force state=IDLE, HRQ=0, DACK=4'b0000, grantValid=0, grantChannel=2'b00, priorityOrder=8'b11_10_01_00.
REQ-030 RESET asserted mid-SERVE SHALL clear DACK and HRQ without waiting for serviceDone; first arbitration after release one cycle after a sampled request.

Configuration
REQ-031 Macro DMA_SW_REQUEST_EN SHALL gate a software request feature.
REQ-032 Defined: extra input swRequest (4 bits); req[i] additionally ORed with swRequest[i], software requests unaffected by maskReg and dreqSenseLow.
REQ-033 Undefined: swRequest port absent; req derived from DREQ and maskReg only.

Verification
REQ-034 Fixed mode, DREQ=4'b1010, HLDA high 2 cycles after HRQ -> DACK=4'b0010, grantChannel=1.
REQ-035 Rotating mode, serviceDone on channel 2 -> priorityOrder=8'b10_01_00_11; then DREQ=4'b0101 -> grant channel 0.
REQ-036 maskReg=4'b0001, DREQ=4'b0001 -> HRQ stays 0; dreqSenseLow=1, DREQ=4'b1110, mask 0 -> grant channel 0.
REQ-037 SERVE on channel 3, DREQ[0] rises -> DACK stays 4'b1000 until serviceDone; HLDA drop mid-SERVE -> DACK=0 next cycle, priorityOrder unchanged.
REQ-038 RESET pulse mid-SERVE (asynchronous, between edges) -> DACK=0, HRQ=0, priorityOrder=8'b11_10_01_00 immediately.
REQ-039 With DMA_SW_REQUEST_EN, swRequest=4'b0100, maskReg=4'b1111 -> DACK=4'b0100 after HLDA.
